// File: rtl/cq_access_scheduler.sv
// Circular-queue access scheduler: round-robin arbitration of two writers and one
// reader over a single-port memory. Optional overwrite-on-full via CQ_OVERWRITE_EN.
module cq_access_scheduler #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [DW-1:0] p0_data,
  output logic          p0_gnt,
  input  logic          p1_req,
  input  logic [DW-1:0] p1_data,
  output logic          p1_gnt,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef CQ_OVERWRITE_EN
  output logic          ovf,
`endif
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_HOLD} rstate_t;
  typedef enum logic [1:0] {SRC_P0, SRC_P1, SRC_RD, SRC_NONE} src_t;

  rstate_t       state, state_nxt;
  src_t          rr_last, sel;
  logic [AW-1:0] head, tail;
  logic          wr_block, elig0, elig1, eligr, wr, rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

`ifdef CQ_OVERWRITE_EN
  assign wr_block = 1'b0;
`else
  assign wr_block = full;
`endif

  // Grants are gated by reset so nothing reaches memory while rst is low.
  assign elig0 = rst && p0_req && !wr_block;
  assign elig1 = rst && p1_req && !wr_block;
  assign eligr = rst && !empty && (state == R_IDLE);

  // Cyclic order P0 -> P1 -> RD, starting after the last winner.
  always_comb begin
    sel = SRC_NONE;
    case (rr_last)
      SRC_P0:  if (elig1) sel = SRC_P1; else if (eligr) sel = SRC_RD; else if (elig0) sel = SRC_P0;
      SRC_P1:  if (eligr) sel = SRC_RD; else if (elig0) sel = SRC_P0; else if (elig1) sel = SRC_P1;
      default: if (elig0) sel = SRC_P0; else if (elig1) sel = SRC_P1; else if (eligr) sel = SRC_RD;
    endcase
  end

  assign p0_gnt    = (sel == SRC_P0);
  assign p1_gnt    = (sel == SRC_P1);
  assign wr        = p0_gnt || p1_gnt;
  assign rd        = (sel == SRC_RD);
  assign mem_en    = wr || rd;
  assign mem_we    = wr;
  assign mem_addr  = rd ? head : tail;
  assign mem_wdata = p1_gnt ? p1_data : p0_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rr_last <= SRC_RD;
    end else begin
      if (sel != SRC_NONE) rr_last <= sel;
      if (wr) begin
        tail <= tail + AW'(1);
`ifdef CQ_OVERWRITE_EN
        // Writing while full lands on the oldest slot; drop it by advancing head.
        if (full) head <= head + AW'(1);
        else      count <= count + (AW+1)'(1);
`else
        count <= count + (AW+1)'(1);
`endif
      end else if (rd) begin
        head  <= head + AW'(1);
        count <= count - (AW+1)'(1);
      end
    end
  end

`ifdef CQ_OVERWRITE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            ovf <= 1'b0;
    else if (wr && full) ovf <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= R_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (rd) state_nxt = R_WAIT;
      R_WAIT:  state_nxt = R_HOLD;
      R_HOLD:  if (out_ready) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == R_HOLD);
  end

  // Memory data arrives the cycle after the read grant, i.e. during R_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 out_data <= '0;
    else if (state == R_WAIT) out_data <= mem_rdata;
  end
endmodule

// File: tb/tb_cq_access_scheduler.sv
// Directed bench for cq_access_scheduler with a 1-cycle-latency single-port memory model.
module tb_cq_access_scheduler;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] p0_data = '0, p1_data = '0;
  logic          p0_gnt, p1_gnt, out_valid, mem_en, mem_we, full, empty;
  logic [DW-1:0] out_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   count;
`ifdef CQ_OVERWRITE_EN
  logic          ovf;
`endif

  logic [DW-1:0] mem [16];
  int            checks = 0, errors = 0;

  cq_access_scheduler #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_data(p0_data), .p0_gnt(p0_gnt),
    .p1_req(p1_req), .p1_data(p1_data), .p1_gnt(p1_gnt),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef CQ_OVERWRITE_EN
    .ovf(ovf),
`endif
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int gcode();
    if (p0_gnt) return 0;
    if (p1_gnt) return 1;
    if (mem_en && !mem_we) return 2;
    return 3;
  endfunction

  // Expected grant order with both writers requesting and the reader interleaving.
  int exp_g [7] = '{0, 1, 2, 0, 1, 0, 1};
  int exp_a [7] = '{0, 1, 0, 2, 3, 4, 5};
  logic [DW-1:0] q [$];
  int wi;

  initial begin
    // reset state, grants suppressed even with a pending request
    p0_req = 1'b1;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_gnt", p0_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    p0_req = 1'b0;
    tick; tick;
    rst = 1'b1;

    // single writer with the reader interleaving
    p0_req = 1'b1; p0_data = 8'h80; #1;
    chk("a_gnt0", p0_gnt, 1); chk("a_addr0", mem_addr, 0); chk("a_wdata0", mem_wdata, 8'h80);
    tick;
    p0_data = 8'h40; #1;
    chk("a_rd_gnt", gcode(), 2); chk("a_rd_addr", mem_addr, 0);
    tick;
    #1;
    chk("a_gnt1", p0_gnt, 1); chk("a_addr1", mem_addr, 1);
    tick;
    p0_data = 8'h20; #1;
    chk("a_gnt2", p0_gnt, 1); chk("a_addr2", mem_addr, 2);
    chk("a_valid", out_valid, 1); chk("a_data", out_data, 8'h80);
    tick;
    p0_req = 1'b0;
    chk("a_count", count, 2);

    // consumer stall: output held, no further read grant
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_data", out_data, 8'h80);
      chk("hold_mem_en", mem_en, 0);
      tick;
    end
    out_ready = 1'b1; #1;
    chk("hold_rel_en", mem_en, 0);
    tick;
    out_ready = 1'b0; #1;
    chk("rel_valid", out_valid, 0);
    chk("rel_rd", gcode(), 2); chk("rel_addr", mem_addr, 1);
    tick; tick;
    chk("hold2_valid", out_valid, 1); chk("hold2_data", out_data, 8'h40);
    rst = 1'b0; #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_data", out_data, 0);
    tick;
    rst = 1'b1;

    // two writers plus reader in round robin
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      p0_data = 8'(8'h10 + i); p1_data = 8'(8'h20 + i); #1;
      chk("rr_gnt", gcode(), exp_g[i]);
      chk("rr_addr", mem_addr, exp_a[i]);
      tick;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("rr_count", count, 5);
    rst = 1'b0; tick; rst = 1'b1;

    // fill to full with wrap; one entry parks in the output register
    p0_req = 1'b1; wi = 0;
    for (int c = 0; c < 60 && wi < 17; c++) begin
      p0_data = 8'(8'h80 + wi * 6); #1;
      if (p0_gnt) begin
        chk("fill_addr", mem_addr, wi % 16);
        q.push_back(p0_data);
        wi++;
      end
      tick;
    end
    p0_req = 1'b0;
    chk("fill_n", wi, 17);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_head_data", out_data, 8'h80);

    p1_req = 1'b1; p1_data = 8'h5A;
`ifdef CQ_OVERWRITE_EN
    #1;
    chk("ovw_gnt", p1_gnt, 1); chk("ovw_addr", mem_addr, 1);
    tick;
    p1_req = 1'b0;
    chk("ovw_ovf", ovf, 1); chk("ovw_count", count, 16);
    q.delete(1);
    q.push_back(8'h5A);
`else
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_block", p1_gnt, 0);
      tick;
    end
    p1_req = 1'b0;
    chk("full_count", count, 16);
`endif

    // drain in write order
    out_ready = 1'b1;
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      if (out_valid) chk("pop", out_data, q.pop_front());
      tick;
    end
    chk("pop_left", q.size(), 0);
    tick;
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
